// File: rtl/qpsk_demodulator_if.sv
// Boundary bundle for the QPSK demodulator: carrier word and rx sample stream in, decided-symbol stream out.
// Latency: none; this file is wiring only.
// Backpressure: symbol_valid/symbol_ready on the decision side. The rx side has no backpressure (one sample per clk).
// Ports: master = demodulator side, slave = front end / framing side.
//   fcw, rx_sample, rx_valid, rx_sync            : carrier word and sample stream
//   symbol_out, symbol_valid, symbol_ready       : decision handshake
//   symbol_weak, i_metric, q_metric, overrun     : decision side-band
interface qpsk_demodulator_if;
  logic        [31:0] fcw;
  logic signed [15:0] rx_sample;
  logic               rx_valid;
  logic               rx_sync;
  logic        [1:0]  symbol_out;
  logic               symbol_valid;
  logic               symbol_ready;
  logic               symbol_weak;
  logic signed [15:0] i_metric;
  logic signed [15:0] q_metric;
  logic               overrun;

  modport master (
    input  fcw, rx_sample, rx_valid, rx_sync, symbol_ready,
    output symbol_out, symbol_valid, symbol_weak, i_metric, q_metric, overrun
  );

  modport slave (
    output fcw, rx_sample, rx_valid, rx_sync, symbol_ready,
    input  symbol_out, symbol_valid, symbol_weak, i_metric, q_metric, overrun
  );
endinterface

// File: rtl/qpsk_demodulator.sv
// Coherent QPSK demodulator: downmix against a local DDS, integrate-and-dump per symbol window, hard decision.
// Latency: symbol_valid rises 3 clks after the last (DUMP) sample of a window is presented.
// Backpressure: a decision is held while symbol_valid && !symbol_ready. A newer decision overwrites it and pulses overrun.
// Ports: clk, reset (synchronous, active-high).
//   bus (master modport): fcw, rx_sample/rx_valid/rx_sync in;
//   symbol_out/symbol_valid/symbol_ready, symbol_weak, i_metric/q_metric, overrun.

module qpsk_demod_dds (
  input  logic               clk,
  input  logic               reset,
  input  logic        [31:0] i_fcw,
  output logic signed [15:0] o_cos,
  output logic signed [15:0] o_sin
);
  logic [31:0] r_phase;
  logic [4:0]  w_ph;

  // Quarter-wave table: round(32767 * sin(k*pi/16)) for k = 0..8.
  function automatic logic signed [15:0] f_qtr(input logic [3:0] k);
    case (k)
      4'd0:    f_qtr = 16'sd0;
      4'd1:    f_qtr = 16'sd6393;
      4'd2:    f_qtr = 16'sd12539;
      4'd3:    f_qtr = 16'sd18204;
      4'd4:    f_qtr = 16'sd23170;
      4'd5:    f_qtr = 16'sd27245;
      4'd6:    f_qtr = 16'sd30273;
      4'd7:    f_qtr = 16'sd32137;
      default: f_qtr = 16'sd32767;
    endcase
  endfunction

  // 32-point sine built from the quarter table: phase bit 3 mirrors the index, bit 4 negates.
  function automatic logic signed [15:0] f_sin(input logic [4:0] p);
    logic        [3:0]  k;
    logic signed [15:0] v;
    k     = p[3] ? (4'd8 - {1'b0, p[2:0]}) : {1'b0, p[2:0]};
    v     = f_qtr(k);
    f_sin = p[4] ? -v : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_phase <= '0;
    else       r_phase <= r_phase + i_fcw;
  end

  assign w_ph  = r_phase[31:27];
  assign o_sin = f_sin(w_ph);
  assign o_cos = f_sin(w_ph + 5'd8);  // cos(x) = sin(x + 90 deg)
endmodule

module qpsk_demodulator #(
  parameter int SYSTEM_CLK_FREQ = 100_000_000,
  parameter int SYMBOL_RATE     = 1_000_000,
  parameter int SYMBOL_PERIOD   = SYSTEM_CLK_FREQ / SYMBOL_RATE,
  parameter int ACC_W           = 32,
  parameter int ENERGY_TH       = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  qpsk_demodulator_if.master bus
);
  localparam int CNT_W = $clog2(SYMBOL_PERIOD);
  localparam int SW    = ACC_W + 1;
  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(SYMBOL_PERIOD - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = -ACC_MAX;

  // Symmetric clamp: -2^(ACC_W-1) is never produced, so |acc| always fits in ACC_W bits.
  function automatic logic signed [ACC_W-1:0] f_sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [16:0]      p);
    logic signed [SW-1:0] s;
    s = SW'(a) + SW'(p);
    if (s > SW'(ACC_MAX))      f_sat_add = ACC_MAX;
    else if (s < SW'(ACC_MIN)) f_sat_add = ACC_MIN;
    else                       f_sat_add = s[ACC_W-1:0];
  endfunction

  function automatic logic signed [15:0] f_metric(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    s = acc >>> 8;
    if (s > ACC_W'(32767))       f_metric = 16'sd32767;
    else if (s < ACC_W'(-32767)) f_metric = -16'sd32767;
    else                         f_metric = 16'(s);
  endfunction

  function automatic logic [ACC_W-1:0] f_abs(input logic signed [ACC_W-1:0] v);
    f_abs = v[ACC_W-1] ? ACC_W'(-v) : v;
  endfunction

  logic signed [15:0]      w_cos, w_sin;
  logic signed [31:0]      w_prod_i, w_prod_q;
  logic signed [16:0]      w_pi, w_pq;
  logic [CNT_W-1:0]        w_idx;
  logic                    w_start, w_dump;
  logic signed [ACC_W-1:0] w_sum_i, w_sum_q;
  logic [SW-1:0]           w_energy;

  logic [CNT_W-1:0]        r_cnt;
  logic signed [16:0]      r_pi, r_pq;
  logic                    r_s1_start, r_s1_dump;
  logic signed [ACC_W-1:0] r_acc_i, r_acc_q, r_fin_i, r_fin_q;
  logic                    r_fin_vld;
  logic                    r_valid, r_weak, r_overrun;
  logic [1:0]              r_sym;
  logic signed [15:0]      r_mi, r_mq;

  qpsk_demod_dds u_dds (
    .clk   (clk),
    .reset (reset),
    .i_fcw (bus.fcw),
    .o_cos (w_cos),
    .o_sin (w_sin)
  );

  // Window index of the sample presented this cycle; rx_sync forces it to 0,
  // which also suppresses a DUMP that would have landed on the same sample.
  assign w_idx   = bus.rx_sync ? '0 : r_cnt;
  assign w_start = (w_idx == '0);
  assign w_dump  = (w_idx == LAST_IDX);

  assign w_prod_i = 32'(bus.rx_sample) * 32'(w_cos);
  assign w_prod_q = -(32'(bus.rx_sample) * 32'(w_sin));
  assign w_pi     = 17'(w_prod_i >>> 15);
  assign w_pq     = 17'(w_prod_q >>> 15);

  // Stage 1: products and window tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_pi       <= '0;
      r_pq       <= '0;
      r_s1_start <= 1'b0;
      r_s1_dump  <= 1'b0;
    end else begin
      r_cnt      <= w_dump ? '0 : w_idx + CNT_W'(1);
      r_pi       <= bus.rx_valid ? w_pi : '0;
      r_pq       <= bus.rx_valid ? w_pq : '0;
      r_s1_start <= w_start;
      r_s1_dump  <= w_dump;
    end
  end

  assign w_sum_i = f_sat_add(r_acc_i, r_pi);
  assign w_sum_q = f_sat_add(r_acc_q, r_pq);

  // Stage 2: integrate-and-dump. START overwrites, so a partial window left behind by rx_sync is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      r_fin_i   <= '0;
      r_fin_q   <= '0;
      r_fin_vld <= 1'b0;
    end else begin
      r_fin_vld <= r_s1_dump;
      if (r_s1_dump) begin
        r_fin_i <= w_sum_i;
        r_fin_q <= w_sum_q;
      end
      if (r_s1_start) begin
        r_acc_i <= ACC_W'(r_pi);
        r_acc_q <= ACC_W'(r_pq);
      end else if (r_s1_dump) begin
        r_acc_i <= '0;
        r_acc_q <= '0;
      end else begin
        r_acc_i <= w_sum_i;
        r_acc_q <= w_sum_q;
      end
    end
  end

  assign w_energy = {1'b0, f_abs(r_fin_i)} + {1'b0, f_abs(r_fin_q)};

  // Stage 3: registered decision and output handshake.
  // Symbol map: bit1 = Q<0, bit0 = (I<0) xor (Q<0).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_sym     <= '0;
      r_weak    <= 1'b0;
      r_mi      <= '0;
      r_mq      <= '0;
      r_overrun <= 1'b0;
    end else if (r_fin_vld) begin
      r_valid   <= 1'b1;
      r_sym     <= {r_fin_q[ACC_W-1], r_fin_i[ACC_W-1] ^ r_fin_q[ACC_W-1]};
      r_weak    <= (w_energy < SW'(ENERGY_TH));
      r_mi      <= f_metric(r_fin_i);
      r_mq      <= f_metric(r_fin_q);
      r_overrun <= r_valid & ~bus.symbol_ready;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && bus.symbol_ready) r_valid <= 1'b0;
    end
  end

  assign bus.symbol_out   = r_sym;
  assign bus.symbol_valid = r_valid;
  assign bus.symbol_weak  = r_weak;
  assign bus.i_metric     = r_mi;
  assign bus.q_metric     = r_mq;
  assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_qpsk_demodulator.sv
// Directed bench for qpsk_demodulator.
// Main instance: fcw = 0x40000000, so the carrier steps 90 deg per clk.
// Per sample n since reset, a transmitted symbol (a = I amplitude, b = Q amplitude) is rx = a*cos - b*sin,
// i.e. rx = a, -b, -a, b for n mod 4 = 0..3. Over a 100-sample window this gives
// I_acc = 50*((a*32767)>>>15) and likewise for Q:
//   a=+16000 -> +799950 (metric 3124); a=-16000 -> -800000 (metric -3125).
// Second instance (window 600, 25-bit integrator, fcw 0): cos stays +32767 and sin stays 0.
// It is used to drive the integrator and the metrics into their clamps.
module tb_qpsk_demodulator;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   g_n   = 0;
  int   g_ovr = 0;
  int   g_vhi = 0;

  always #5 clk = ~clk;

  qpsk_demodulator_if bus ();
  qpsk_demodulator_if bus2 ();

  qpsk_demodulator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  qpsk_demodulator #(.SYMBOL_PERIOD(600), .ACC_W(25)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  function automatic logic signed [15:0] rx_for(input int a, input int b, input int n);
    case (n % 4)
      0:       return 16'(a);
      1:       return 16'(-b);
      2:       return 16'(-a);
      default: return 16'(b);
    endcase
  endfunction

  // Drive one sample at a negedge. The next posedge consumes it; return at the following negedge.
  task automatic put(input logic signed [15:0] rx, input logic vld, input logic sync);
    bus.rx_sample = rx;
    bus.rx_valid  = vld;
    bus.rx_sync   = sync;
    @(negedge clk);
    g_n++;
    if (bus.overrun === 1'b1) g_ovr++;
    if (bus.symbol_valid === 1'b1) g_vhi++;
  endtask

  task automatic put2(input logic signed [15:0] rx, input logic vld, input logic sync);
    bus2.rx_sample = rx;
    bus2.rx_valid  = vld;
    bus2.rx_sync   = sync;
    @(negedge clk);
  endtask

  task automatic send_sym(input int a, input int b, input int len, input logic sync_first);
    for (int i = 0; i < len; i++) put(rx_for(a, b, g_n), 1'b1, sync_first && (i == 0));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.symbol_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", bus.symbol_valid); end
    n_cmp++; if (bus.symbol_out !== 2'b00) begin n_bad++; $display("FAIL reset_symbol got=%b want=00", bus.symbol_out); end
    n_cmp++; if (bus.symbol_weak !== 1'b0) begin n_bad++; $display("FAIL reset_weak got=%b want=0", bus.symbol_weak); end
    n_cmp++; if (bus.i_metric !== 16'sd0) begin n_bad++; $display("FAIL reset_i_metric got=%0d want=0", bus.i_metric); end
    n_cmp++; if (bus.q_metric !== 16'sd0) begin n_bad++; $display("FAIL reset_q_metric got=%0d want=0", bus.q_metric); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got=%b want=0", bus.overrun); end
    reset = 1'b0;
    g_n = 0;
  endtask

  task automatic test_loop();
    logic [1:0]         s;
    int                 a, b;
    logic signed [15:0] ei, eq;
    bus.symbol_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s  = 2'(k);
      a  = (s == 2'b01 || s == 2'b10) ? -16000 : 16000;
      b  = s[1] ? -16000 : 16000;
      ei = (a > 0) ? 16'sd3124 : -16'sd3125;
      eq = (b > 0) ? 16'sd3124 : -16'sd3125;
      send_sym(a, b, 100, 1'b1);
      put(16'sd0, 1'b0, 1'b0);
      n_cmp++; if (bus.symbol_valid !== 1'b0) begin n_bad++; $display("FAIL loop_latency sym=%b got_valid=%b want=0", s, bus.symbol_valid); end
      put(16'sd0, 1'b0, 1'b0);
      n_cmp++; if ({bus.symbol_valid, bus.symbol_out, bus.symbol_weak} !== {1'b1, s, 1'b0}) begin
        n_bad++; $display("FAIL loop_decision got v/sym/weak=%b/%b/%b want 1/%b/0", bus.symbol_valid, bus.symbol_out, bus.symbol_weak, s);
      end
      n_cmp++; if (bus.i_metric !== ei) begin n_bad++; $display("FAIL loop_i_metric sym=%b got=%0d want=%0d", s, bus.i_metric, ei); end
      n_cmp++; if (bus.q_metric !== eq) begin n_bad++; $display("FAIL loop_q_metric sym=%b got=%0d want=%0d", s, bus.q_metric, eq); end
      put(16'sd0, 1'b0, 1'b0);
      n_cmp++; if (bus.symbol_valid !== 1'b0) begin n_bad++; $display("FAIL loop_accept sym=%b got_valid=%b want=0", s, bus.symbol_valid); end
    end
  endtask

  task automatic test_zero_window();
    bus.symbol_ready = 1'b1;
    for (int i = 0; i < 100; i++) put(16'sd0, 1'b1, i == 0);
    put(16'sd0, 1'b0, 1'b0);
    put(16'sd0, 1'b0, 1'b0);
    n_cmp++; if ({bus.symbol_valid, bus.symbol_out, bus.symbol_weak} !== 4'b1001) begin
      n_bad++; $display("FAIL zero_decision got v/sym/weak=%b/%b/%b want 1/00/1", bus.symbol_valid, bus.symbol_out, bus.symbol_weak);
    end
    n_cmp++; if (bus.i_metric !== 16'sd0 || bus.q_metric !== 16'sd0) begin
      n_bad++; $display("FAIL zero_metrics got i=%0d q=%0d want 0/0", bus.i_metric, bus.q_metric);
    end
    put(16'sd0, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    int ovr0;
    bus.symbol_ready = 1'b0;
    send_sym(-16000, 16000, 100, 1'b1);
    put(16'sd0, 1'b0, 1'b0);
    put(16'sd0, 1'b0, 1'b0);
    ovr0 = g_ovr;
    n_cmp++; if ({bus.symbol_valid, bus.symbol_out} !== 3'b101) begin n_bad++; $display("FAIL ovr_first got v/sym=%b/%b want 1/01", bus.symbol_valid, bus.symbol_out); end
    send_sym(-16000, -16000, 100, 1'b1);
    n_cmp++; if ({bus.symbol_valid, bus.symbol_out} !== 3'b101) begin n_bad++; $display("FAIL ovr_hold got v/sym=%b/%b want 1/01", bus.symbol_valid, bus.symbol_out); end
    put(16'sd0, 1'b0, 1'b0);
    put(16'sd0, 1'b0, 1'b0);
    n_cmp++; if ({bus.symbol_valid, bus.symbol_out, bus.overrun} !== 4'b1101) begin
      n_bad++; $display("FAIL ovr_replace got v/sym/ovr=%b/%b/%b want 1/10/1", bus.symbol_valid, bus.symbol_out, bus.overrun);
    end
    n_cmp++; if (bus.i_metric !== -16'sd3125 || bus.q_metric !== -16'sd3125) begin
      n_bad++; $display("FAIL ovr_metrics got i=%0d q=%0d want -3125/-3125", bus.i_metric, bus.q_metric);
    end
    put(16'sd0, 1'b0, 1'b0);
    n_cmp++; if ({bus.symbol_valid, bus.overrun} !== 2'b10) begin n_bad++; $display("FAIL ovr_pulse_end got v/ovr=%b/%b want 1/0", bus.symbol_valid, bus.overrun); end
    n_cmp++; if (g_ovr - ovr0 !== 1) begin n_bad++; $display("FAIL ovr_count got=%0d want=1", g_ovr - ovr0); end
    bus.symbol_ready = 1'b1;
    put(16'sd0, 1'b0, 1'b0);
    n_cmp++; if (bus.symbol_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_accept got_valid=%b want=0", bus.symbol_valid); end
  endtask

  task automatic test_sync_mid();
    int v0;
    bus.symbol_ready = 1'b1;
    v0 = g_vhi;
    send_sym(-16000, -16000, 40, 1'b1);
    send_sym(16000, 16000, 100, 1'b1);
    put(16'sd0, 1'b0, 1'b0);
    n_cmp++; if (g_vhi !== v0) begin n_bad++; $display("FAIL sync_no_partial got valid_cycles=%0d want=0", g_vhi - v0); end
    put(16'sd0, 1'b0, 1'b0);
    n_cmp++; if ({bus.symbol_valid, bus.symbol_out} !== 3'b100) begin n_bad++; $display("FAIL sync_decision got v/sym=%b/%b want 1/00", bus.symbol_valid, bus.symbol_out); end
    n_cmp++; if (bus.i_metric !== 16'sd3124 || bus.q_metric !== 16'sd3124) begin
      n_bad++; $display("FAIL sync_metrics got i=%0d q=%0d want 3124/3124", bus.i_metric, bus.q_metric);
    end
    put(16'sd0, 1'b0, 1'b0);
  endtask

  task automatic test_midreset();
    int v0;
    bus.symbol_ready = 1'b0;
    send_sym(16000, 16000, 100, 1'b1);
    put(16'sd0, 1'b0, 1'b0);
    put(16'sd0, 1'b0, 1'b0);
    n_cmp++; if (bus.symbol_valid !== 1'b1) begin n_bad++; $display("FAIL mrst_pending got_valid=%b want=1", bus.symbol_valid); end
    send_sym(16000, -16000, 50, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.symbol_valid, bus.symbol_out, bus.symbol_weak, bus.overrun} !== 5'b0) begin
      n_bad++; $display("FAIL mrst_outputs got v/sym/weak/ovr=%b/%b/%b/%b want 0/00/0/0", bus.symbol_valid, bus.symbol_out, bus.symbol_weak, bus.overrun);
    end
    n_cmp++; if (bus.i_metric !== 16'sd0 || bus.q_metric !== 16'sd0) begin
      n_bad++; $display("FAIL mrst_metrics got i=%0d q=%0d want 0/0", bus.i_metric, bus.q_metric);
    end
    reset = 1'b0;
    g_n = 0;
    v0 = g_vhi;
    send_sym(16000, -16000, 100, 1'b0);
    put(16'sd0, 1'b0, 1'b0);
    n_cmp++; if (g_vhi !== v0) begin n_bad++; $display("FAIL mrst_early got valid_cycles=%0d want=0", g_vhi - v0); end
    put(16'sd0, 1'b0, 1'b0);
    n_cmp++; if ({bus.symbol_valid, bus.symbol_out} !== 3'b111) begin n_bad++; $display("FAIL mrst_next got v/sym=%b/%b want 1/11", bus.symbol_valid, bus.symbol_out); end
    n_cmp++; if (bus.i_metric !== 16'sd3124 || bus.q_metric !== -16'sd3125) begin
      n_bad++; $display("FAIL mrst_metrics_next got i=%0d q=%0d want 3124/-3125", bus.i_metric, bus.q_metric);
    end
  endtask

  task automatic test_saturation();
    bus.rx_valid       = 1'b0;
    bus.rx_sync        = 1'b0;
    bus2.symbol_ready  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    // +32767 * cos(+32767) >>> 15 = +32766 per sample; 600 samples exceed the 25-bit integrator.
    for (int i = 0; i < 600; i++) put2(16'sd32767, 1'b1, i == 0);
    put2(16'sd0, 1'b0, 1'b0);
    put2(16'sd0, 1'b0, 1'b0);
    n_cmp++; if ({bus2.symbol_valid, bus2.symbol_out, bus2.symbol_weak} !== 4'b1000) begin
      n_bad++; $display("FAIL sat_pos_decision got v/sym/weak=%b/%b/%b want 1/00/0", bus2.symbol_valid, bus2.symbol_out, bus2.symbol_weak);
    end
    n_cmp++; if (bus2.i_metric !== 16'sd32767 || bus2.q_metric !== 16'sd0) begin
      n_bad++; $display("FAIL sat_pos_metrics got i=%0d q=%0d want 32767/0", bus2.i_metric, bus2.q_metric);
    end
    // -32768 * 32767 >>> 15 = -32767 per sample; the clamp must stop at -(2^24-1), and the metric at -32767.
    for (int i = 0; i < 600; i++) put2(-16'sd32768, 1'b1, i == 0);
    put2(16'sd0, 1'b0, 1'b0);
    put2(16'sd0, 1'b0, 1'b0);
    n_cmp++; if ({bus2.symbol_valid, bus2.symbol_out} !== 3'b101) begin
      n_bad++; $display("FAIL sat_neg_decision got v/sym=%b/%b want 1/01", bus2.symbol_valid, bus2.symbol_out);
    end
    n_cmp++; if (bus2.i_metric !== -16'sd32767) begin n_bad++; $display("FAIL sat_neg_i_metric got=%0d want=-32767", bus2.i_metric); end
  endtask

  initial begin
    reset             = 1'b1;
    bus.fcw           = 32'h4000_0000;
    bus.rx_sample     = '0;
    bus.rx_valid      = 1'b0;
    bus.rx_sync       = 1'b0;
    bus.symbol_ready  = 1'b0;
    bus2.fcw          = 32'h0;
    bus2.rx_sample    = '0;
    bus2.rx_valid     = 1'b0;
    bus2.rx_sync      = 1'b0;
    bus2.symbol_ready = 1'b0;
    test_reset();
    test_loop();
    test_zero_window();
    test_overrun();
    test_sync_mid();
    test_midreset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
